// File: rtl/pipe_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_t;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  // Every MEM/WB field is filled with this bit when a bubble is loaded.
  localparam logic MEMWB_BUBBLE = 1'b0;

endpackage

// File: rtl/pipe_mem_wb.sv
// MEM/WB pipeline register; loads either the presented fields or a bubble every cycle.
module pipe_mem_wb
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bubble_i,
  input  logic             memtoreg_i,
  input  logic             regwrite_i,
  input  logic [WIDTH-1:0] resultop_i,
  input  logic [WIDTH-1:0] rddata_i,
  input  logic [RA_W-1:0]  ard_i,
  output logic             memtoreg_o,
  output logic             regwrite_o,
  output logic [WIDTH-1:0] resultop_o,
  output logic [WIDTH-1:0] rddata_o,
  output logic [RA_W-1:0]  ard_o
);

  logic             memtoreg_q;
  logic             regwrite_q;
  logic [WIDTH-1:0] resultop_q;
  logic [WIDTH-1:0] rddata_q;
  logic [RA_W-1:0]  ard_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memtoreg_q <= 1'b0;
      regwrite_q <= 1'b0;
      resultop_q <= '0;
      rddata_q   <= '0;
      ard_q      <= '0;
    end else if (bubble_i) begin
      memtoreg_q <= MEMWB_BUBBLE;
      regwrite_q <= MEMWB_BUBBLE;
      resultop_q <= {WIDTH{MEMWB_BUBBLE}};
      rddata_q   <= {WIDTH{MEMWB_BUBBLE}};
      ard_q      <= {RA_W{MEMWB_BUBBLE}};
    end else begin
      memtoreg_q <= memtoreg_i;
      regwrite_q <= regwrite_i;
      resultop_q <= resultop_i;
      rddata_q   <= rddata_i;
      ard_q      <= ard_i;
    end
  end

  assign memtoreg_o = memtoreg_q;
  assign regwrite_o = regwrite_q;
  assign resultop_o = resultop_q;
  assign rddata_o   = rddata_q;
  assign ard_o      = ard_q;

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: word accesses over a req/gnt/rvalid bus, stalling upstream while busy.
//  state | meaning
//  IDLE  | accept EX/MEM every cycle; ALU ops pass through, aligned memops latch and start
//  REQ   | DM_REQ held with latched address/data until DM_GNT
//  WAIT  | load granted, waiting for DM_RVALID
module mem_stage_lsu
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MEMWRITE_IN,
  input  logic             MEMTOREG_IN,
  input  logic             REGWRITE_IN,
  input  logic [WIDTH-1:0] RESULTOP_IN,
  input  logic [WIDTH-1:0] WRDATA_IN,
  input  logic [RA_W-1:0]  ARD_IN,
  output logic             DM_REQ,
  output logic             DM_WE,
  output logic [WIDTH-1:0] DM_ADDR,
  output logic [WIDTH-1:0] DM_WDATA,
  input  logic             DM_GNT,
  input  logic             DM_RVALID,
  input  logic [WIDTH-1:0] DM_RDATA,
  output logic             STALL,
  output logic             ERR_OUT,
  output logic             MEMTOREG_OUT,
  output logic             REGWRITE_OUT,
  output logic [WIDTH-1:0] RESULTOP_OUT,
  output logic [WIDTH-1:0] RDDATA_OUT,
  output logic [RA_W-1:0]  ARD_OUT
);

  lsu_state_t       state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [RA_W-1:0]  ard_q, ard_d;
  logic             rw_q, rw_d;
  logic             store_q, store_d;
  logic             err_q, err_d;

  logic             memop;
  logic             misaligned;

  logic             wb_bubble;
  logic             wb_memtoreg;
  logic             wb_regwrite;
  logic [WIDTH-1:0] wb_resultop;
  logic [WIDTH-1:0] wb_rddata;
  logic [RA_W-1:0]  wb_ard;

  assign memop      = MEMWRITE_IN | MEMTOREG_IN;
  assign misaligned = |(RESULTOP_IN[1:0] & WORD_ALIGN_MASK);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      ard_q   <= '0;
      rw_q    <= 1'b0;
      store_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ard_q   <= ard_d;
      rw_q    <= rw_d;
      store_q <= store_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ard_d       = ard_q;
    rw_d        = rw_q;
    store_d     = store_q;
    err_d       = 1'b0;
    wb_bubble   = 1'b1;
    wb_memtoreg = 1'b0;
    wb_regwrite = 1'b0;
    wb_resultop = '0;
    wb_rddata   = '0;
    wb_ard      = '0;

    case (state_q)
      IDLE: begin
        if (memop) begin
          if (misaligned) begin
            err_d = 1'b1;
          end else begin
            // A combined store+load request is treated as a store that writes no register.
            addr_d  = RESULTOP_IN;
            wdata_d = WRDATA_IN;
            ard_d   = ARD_IN;
            store_d = MEMWRITE_IN;
            rw_d    = REGWRITE_IN & ~MEMWRITE_IN;
            state_d = REQ;
          end
        end else begin
          wb_bubble   = 1'b0;
          wb_regwrite = REGWRITE_IN;
          wb_resultop = RESULTOP_IN;
          wb_ard      = ARD_IN;
        end
      end
      REQ: begin
        if (DM_GNT) begin
          if (store_q) begin
            state_d     = IDLE;
            wb_bubble   = 1'b0;
            wb_resultop = addr_q;
            wb_ard      = ard_q;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (DM_RVALID) begin
          state_d     = IDLE;
          wb_bubble   = 1'b0;
          wb_memtoreg = 1'b1;
          wb_regwrite = rw_q;
          wb_resultop = addr_q;
          wb_rddata   = DM_RDATA;
          wb_ard      = ard_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign STALL    = (state_q != IDLE);
  assign DM_REQ   = (state_q == REQ);
  assign DM_WE    = DM_REQ & store_q;
  assign DM_ADDR  = DM_REQ ? addr_q  : '0;
  assign DM_WDATA = DM_REQ ? wdata_q : '0;
  assign ERR_OUT  = err_q;

  pipe_mem_wb #(
    .WIDTH (WIDTH),
    .RA_W  (RA_W)
  ) u_mem_wb (
    .clk        (clk),
    .rst_n      (rst),
    .bubble_i   (wb_bubble),
    .memtoreg_i (wb_memtoreg),
    .regwrite_i (wb_regwrite),
    .resultop_i (wb_resultop),
    .rddata_i   (wb_rddata),
    .ard_i      (wb_ard),
    .memtoreg_o (MEMTOREG_OUT),
    .regwrite_o (REGWRITE_OUT),
    .resultop_o (RESULTOP_OUT),
    .rddata_o   (RDDATA_OUT),
    .ard_o      (ARD_OUT)
  );

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: single-cycle vector table plus hand-written bus sequences.
module tb_mem_stage_lsu;

  logic        clk;
  logic        rst;
  logic        mw, mr, rw;
  logic [31:0] res, wd;
  logic [4:0]  ard;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;
  logic        stall, err;
  logic        memtoreg_o, regwrite_o;
  logic [31:0] resultop_o, rddata_o;
  logic [4:0]  ard_o;

  int tests = 0;
  int fails = 0;

  mem_stage_lsu dut (
    .clk          (clk),
    .rst          (rst),
    .MEMWRITE_IN  (mw),
    .MEMTOREG_IN  (mr),
    .REGWRITE_IN  (rw),
    .RESULTOP_IN  (res),
    .WRDATA_IN    (wd),
    .ARD_IN       (ard),
    .DM_REQ       (dm_req),
    .DM_WE        (dm_we),
    .DM_ADDR      (dm_addr),
    .DM_WDATA     (dm_wdata),
    .DM_GNT       (dm_gnt),
    .DM_RVALID    (dm_rvalid),
    .DM_RDATA     (dm_rdata),
    .STALL        (stall),
    .ERR_OUT      (err),
    .MEMTOREG_OUT (memtoreg_o),
    .REGWRITE_OUT (regwrite_o),
    .RESULTOP_OUT (resultop_o),
    .RDDATA_OUT   (rddata_o),
    .ARD_OUT      (ard_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mw, mr, rw;
    logic [31:0] res, wd;
    logic [4:0]  ard;
    logic        e_rw, e_mr, e_err;
    logic [31:0] e_res;
    logic [4:0]  e_ard;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic m_w, input logic m_r, input logic r_w,
                       input logic [31:0] r, input logic [31:0] w, input logic [4:0] a);
    mw = m_w; mr = m_r; rw = r_w; res = r; wd = w; ard = a;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " DM_REQ"},   32'(dm_req), 32'd0);
    chk({tag, " STALL"},    32'(stall), 32'd0);
    chk({tag, " ERR"},      32'(err), 32'd0);
    chk({tag, " REGWRITE"}, 32'(regwrite_o), 32'd0);
    chk({tag, " MEMTOREG"}, 32'(memtoreg_o), 32'd0);
    chk({tag, " RESULTOP"}, resultop_o, 32'd0);
    chk({tag, " RDDATA"},   rddata_o, 32'd0);
    chk({tag, " ARD"},      32'(ard_o), 32'd0);
    chk({tag, " DM_WE"},    32'(dm_we), 32'd0);
    chk({tag, " DM_ADDR"},  dm_addr, 32'd0);
  endtask

  initial begin
    //               mw    mr    rw    res            wd             ard       e_rw  e_mr  e_err e_res          e_ard
    vecs[0] = '{1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 32'h00000000, 5'b10101, 1'b1, 1'b0, 1'b0, 32'hA5A5A5A5, 5'b10101};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 32'h12345678, 32'hFFFFFFFF, 5'd3,     1'b0, 1'b0, 1'b0, 32'h12345678, 5'd3};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h00000102, 32'h00000000, 5'd7,     1'b0, 1'b0, 1'b1, 32'h00000000, 5'd0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h00000001, 32'h0000DEAD, 5'd4,     1'b0, 1'b0, 1'b1, 32'h00000000, 5'd0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h00000203, 32'h11111111, 5'd9,     1'b0, 1'b0, 1'b1, 32'h00000000, 5'd0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000000, 5'd31,    1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 5'd31};

    // Reset with random inputs, including a bus that claims to respond.
    rst = 1'b0;
    drive(1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom));
    dm_gnt = 1'b1; dm_rvalid = 1'b1; dm_rdata = $urandom;
    step();
    step();
    chk_all_zero("reset");
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'h0;
    rst = 1'b1;
    step();

    // Single-cycle IDLE behaviour: ALU pass-through and misaligned memops.
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].mw, vecs[i].mr, vecs[i].rw, vecs[i].res, vecs[i].wd, vecs[i].ard);
      step();
      chk($sformatf("vec%0d REGWRITE", i), 32'(regwrite_o), 32'(vecs[i].e_rw));
      chk($sformatf("vec%0d MEMTOREG", i), 32'(memtoreg_o), 32'(vecs[i].e_mr));
      chk($sformatf("vec%0d RESULTOP", i), resultop_o, vecs[i].e_res);
      chk($sformatf("vec%0d ARD", i), 32'(ard_o), 32'(vecs[i].e_ard));
      chk($sformatf("vec%0d RDDATA", i), rddata_o, 32'h0);
      chk($sformatf("vec%0d ERR", i), 32'(err), 32'(vecs[i].e_err));
      chk($sformatf("vec%0d STALL", i), 32'(stall), 32'd0);
      chk($sformatf("vec%0d DM_REQ", i), 32'(dm_req), 32'd0);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    chk("idle ERR cleared", 32'(err), 32'd0);

    // Store to 0x100, granted in the third REQ cycle; an ALU op waits upstream.
    drive(1'b1, 1'b0, 1'b1, 32'h00000100, 32'h55555555, 5'd2);
    step();
    drive(1'b0, 1'b0, 1'b1, 32'h00000077, 32'h0, 5'd6);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("st req%0d DM_REQ", c), 32'(dm_req), 32'd1);
      chk($sformatf("st req%0d DM_WE", c), 32'(dm_we), 32'd1);
      chk($sformatf("st req%0d DM_ADDR", c), dm_addr, 32'h00000100);
      chk($sformatf("st req%0d DM_WDATA", c), dm_wdata, 32'h55555555);
      chk($sformatf("st req%0d STALL", c), 32'(stall), 32'd1);
      chk($sformatf("st req%0d REGWRITE", c), 32'(regwrite_o), 32'd0);
      if (c == 2) dm_gnt = 1'b1;
      step();
    end
    dm_gnt = 1'b0;
    chk("st done STALL", 32'(stall), 32'd0);
    chk("st done DM_REQ", 32'(dm_req), 32'd0);
    chk("st done REGWRITE", 32'(regwrite_o), 32'd0);
    chk("st done MEMTOREG", 32'(memtoreg_o), 32'd0);
    chk("st done RESULTOP", resultop_o, 32'h00000100);
    step();
    chk("st next REGWRITE", 32'(regwrite_o), 32'd1);
    chk("st next RESULTOP", resultop_o, 32'h00000077);
    chk("st next ARD", 32'(ard_o), 32'd6);

    // Load from 0x40, immediate grant, data two cycles after the grant cycle.
    drive(1'b0, 1'b1, 1'b1, 32'h00000040, 32'h0, 5'b01010);
    dm_gnt = 1'b1;
    step();
    drive(1'b0, 1'b0, 1'b1, 32'h0000ABCD, 32'h0, 5'b01111);
    chk("ld req DM_REQ", 32'(dm_req), 32'd1);
    chk("ld req DM_WE", 32'(dm_we), 32'd0);
    chk("ld req DM_ADDR", dm_addr, 32'h00000040);
    chk("ld req STALL", 32'(stall), 32'd1);
    step();
    dm_gnt = 1'b0;
    chk("ld wait1 DM_REQ", 32'(dm_req), 32'd0);
    chk("ld wait1 STALL", 32'(stall), 32'd1);
    chk("ld wait1 REGWRITE", 32'(regwrite_o), 32'd0);
    step();
    chk("ld wait2 STALL", 32'(stall), 32'd1);
    chk("ld wait2 MEMTOREG", 32'(memtoreg_o), 32'd0);
    dm_rvalid = 1'b1; dm_rdata = 32'h12345678;
    step();
    dm_rvalid = 1'b0; dm_rdata = 32'h0;
    chk("ld done MEMTOREG", 32'(memtoreg_o), 32'd1);
    chk("ld done REGWRITE", 32'(regwrite_o), 32'd1);
    chk("ld done RDDATA", rddata_o, 32'h12345678);
    chk("ld done ARD", 32'(ard_o), 32'b01010);
    chk("ld done RESULTOP", resultop_o, 32'h00000040);
    chk("ld done STALL", 32'(stall), 32'd0);
    step();
    chk("ld next MEMTOREG", 32'(memtoreg_o), 32'd0);
    chk("ld next REGWRITE", 32'(regwrite_o), 32'd1);
    chk("ld next RESULTOP", resultop_o, 32'h0000ABCD);
    chk("ld next RDDATA", rddata_o, 32'h0);
    chk("ld next ARD", 32'(ard_o), 32'b01111);

    // Reset while waiting for load data; a late RVALID must be ignored.
    drive(1'b0, 1'b1, 1'b1, 32'h00000080, 32'h0, 5'd12);
    dm_gnt = 1'b1;
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    dm_gnt = 1'b0;
    chk("rstw pre STALL", 32'(stall), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rstw DM_REQ", 32'(dm_req), 32'd0);
    chk("rstw STALL", 32'(stall), 32'd0);
    step();
    rst = 1'b1;
    dm_rvalid = 1'b1; dm_rdata = 32'hDEADBEEF;
    step();
    dm_rvalid = 1'b0; dm_rdata = 32'h0;
    chk("rstw late MEMTOREG", 32'(memtoreg_o), 32'd0);
    chk("rstw late REGWRITE", 32'(regwrite_o), 32'd0);
    chk("rstw late RDDATA", rddata_o, 32'h0);
    chk("rstw late STALL", 32'(stall), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
